sodor_internal_tile: RTL and testbench



---
 rtl/sodor_internal_tile.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_sodor_internal_tile.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sodor_internal_tile.sv
// Single-cycle RV32I tile: core (datapath d), word-addressed text memory, data and stack scratchpads.
// Fetch, decode, execute and memory read are combinational from the PC; state updates on the rising edge.

module sodor_text_mem (
  input  logic        clock,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_data,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata
);
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned WORDS = 1200;
  localparam logic [31:0] BYTES = 32'(WORDS * 4);

  logic [31:0] mem [0:WORDS-1];
  logic [31:0] f_off, d_off;
  logic        f_hit;

  assign f_off      = fetch_addr - BASE;
  assign d_off      = addr - BASE;
  assign f_hit      = f_off < BYTES;
  assign hit        = d_off < BYTES;
  assign fetch_data = f_hit ? mem[f_off[12:2]] : 32'h0000_0013;
  assign rdata      = hit ? mem[d_off[12:2]] : '0;

  always_ff @(posedge clock) begin
    if (we && hit) begin
      for (int unsigned i = 0; i < 4; i++)
        if (be[i]) mem[d_off[12:2]][8*i +: 8] <= wdata[8*i +: 8];
    end
  end
endmodule

module sodor_scratchpad #(
  parameter logic [31:0] BASE  = 32'h8000_1000,
  parameter int unsigned WORDS = 768
) (
  input  logic        clock,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata
);
  localparam int unsigned AW    = $clog2(WORDS);
  localparam logic [31:0] BYTES = 32'(WORDS * 4);

  logic [31:0] mem [0:WORDS-1];
  logic [31:0] off;

  assign off   = addr - BASE;
  assign hit   = off < BYTES;
  assign rdata = hit ? mem[off[AW+1:2]] : '0;

  always_ff @(posedge clock) begin
    if (we && hit) begin
      for (int unsigned i = 0; i < 4; i++)
        if (be[i]) mem[off[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
    end
  end
endmodule

module sodor_dpath (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] io_imem_req_bits_addr,
  input  logic [31:0] io_imem_resp_bits_data,
  output logic [31:0] io_dmem_req_bits_addr,
  output logic [31:0] io_dmem_req_bits_data,
  output logic [3:0]  io_dmem_req_bits_mask,
  output logic        io_dmem_req_wr,
  input  logic [31:0] io_dmem_resp_bits_data
);
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] STACK_TOP = 32'h8002_1000;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'h37,
    OPC_AUIPC  = 7'h17,
    OPC_JAL    = 7'h6f,
    OPC_JALR   = 7'h67,
    OPC_BRANCH = 7'h63,
    OPC_LOAD   = 7'h03,
    OPC_STORE  = 7'h23,
    OPC_OP_IMM = 7'h13,
    OPC_OP     = 7'h33
  } opcode_e;

  logic [31:0] pc, inst, next_pc;
  logic [31:0] regfile [0:31];
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_b, alu_out, ld_data, wb_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        alt, br_taken, wb_en;

  assign io_imem_req_bits_addr = pc;
  assign inst   = io_imem_resp_bits_data;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  assign rs1_data = (rs1 == '0) ? '0 : regfile[rs1];
  assign rs2_data = (rs2 == '0) ? '0 : regfile[rs2];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'h000};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // inst[30] selects SUB/SRA for register ops but only SRAI among immediate ops
  assign alu_b = (opcode == OPC_OP) ? rs2_data : imm_i;
  assign shamt = alu_b[4:0];
  assign alt   = inst[30] && ((opcode == OPC_OP) || (funct3 == 3'b101));

  always_comb begin
    alu_out = '0;
    case (funct3)
      3'd0: alu_out = alt ? rs1_data - alu_b : rs1_data + alu_b;
      3'd1: alu_out = rs1_data << shamt;
      3'd2: alu_out = {31'd0, $signed(rs1_data) < $signed(alu_b)};
      3'd3: alu_out = {31'd0, rs1_data < alu_b};
      3'd4: alu_out = rs1_data ^ alu_b;
      3'd5: alu_out = alt ? 32'($signed(rs1_data) >>> shamt) : rs1_data >> shamt;
      3'd6: alu_out = rs1_data | alu_b;
      default: alu_out = rs1_data & alu_b;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'd0: br_taken = rs1_data == rs2_data;
      3'd1: br_taken = rs1_data != rs2_data;
      3'd4: br_taken = $signed(rs1_data) < $signed(rs2_data);
      3'd5: br_taken = $signed(rs1_data) >= $signed(rs2_data);
      3'd6: br_taken = rs1_data < rs2_data;
      3'd7: br_taken = rs1_data >= rs2_data;
      default: br_taken = 1'b0;
    endcase
  end

  assign io_dmem_req_bits_addr = rs1_data + ((opcode == OPC_STORE) ? imm_s : imm_i);

  always_comb begin
    io_dmem_req_bits_data = rs2_data;
    io_dmem_req_bits_mask = '0;
    case (funct3)
      3'd0: begin
        io_dmem_req_bits_data = {4{rs2_data[7:0]}};
        io_dmem_req_bits_mask = 4'b0001 << io_dmem_req_bits_addr[1:0];
      end
      3'd1: begin
        io_dmem_req_bits_data = {2{rs2_data[15:0]}};
        io_dmem_req_bits_mask = io_dmem_req_bits_addr[1] ? 4'b1100 : 4'b0011;
      end
      3'd2:    io_dmem_req_bits_mask = 4'b1111;
      default: io_dmem_req_bits_mask = '0;
    endcase
    io_dmem_req_wr = !reset && (opcode == OPC_STORE) && (io_dmem_req_bits_mask != '0);
  end

  // Misaligned loads pick lanes from the aligned word instead of trapping
  assign ld_byte = io_dmem_resp_bits_data[{io_dmem_req_bits_addr[1:0], 3'b000} +: 8];
  assign ld_half = io_dmem_resp_bits_data[{io_dmem_req_bits_addr[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = io_dmem_resp_bits_data;
    case (funct3)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = io_dmem_resp_bits_data;
    endcase
  end

  always_comb begin
    next_pc = pc + 32'd4;
    wb_en   = 1'b0;
    wb_data = alu_out;
    case (opcode)
      OPC_LUI:    begin wb_en = 1'b1; wb_data = imm_u; end
      OPC_AUIPC:  begin wb_en = 1'b1; wb_data = pc + imm_u; end
      OPC_JAL:    begin wb_en = 1'b1; wb_data = pc + 32'd4; next_pc = pc + imm_j; end
      OPC_JALR: begin
        wb_en   = 1'b1;
        wb_data = pc + 32'd4;
        next_pc = (rs1_data + imm_i) & ~32'd1;
      end
      OPC_BRANCH: if (br_taken) next_pc = pc + imm_b;
      OPC_LOAD: begin
        wb_en   = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
        wb_data = ld_data;
      end
      OPC_OP_IMM, OPC_OP: wb_en = 1'b1;
      default: wb_en = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
      for (int unsigned i = 0; i < 32; i++)
        regfile[5'(i)] <= (i == 2) ? STACK_TOP : '0;
    end else begin
      pc <= next_pc;
      if (wb_en && (rd != '0)) regfile[rd] <= wb_data;
    end
  end
endmodule

module sodor_core (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] io_imem_req_bits_addr,
  input  logic [31:0] io_imem_resp_bits_data,
  output logic [31:0] io_dmem_req_bits_addr,
  output logic [31:0] io_dmem_req_bits_data,
  output logic [3:0]  io_dmem_req_bits_mask,
  output logic        io_dmem_req_wr,
  input  logic [31:0] io_dmem_resp_bits_data
);
  sodor_dpath d (
    .clock                  (clock),
    .reset                  (reset),
    .io_imem_req_bits_addr  (io_imem_req_bits_addr),
    .io_imem_resp_bits_data (io_imem_resp_bits_data),
    .io_dmem_req_bits_addr  (io_dmem_req_bits_addr),
    .io_dmem_req_bits_data  (io_dmem_req_bits_data),
    .io_dmem_req_bits_mask  (io_dmem_req_bits_mask),
    .io_dmem_req_wr         (io_dmem_req_wr),
    .io_dmem_resp_bits_data (io_dmem_resp_bits_data)
  );
endmodule

module sodor_internal_tile (
  input logic clock,
  input logic reset
);
  logic [31:0] imem_addr, imem_data;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] text_rdata, data_rdata, stack_rdata;
  logic [3:0]  dmem_mask;
  logic        dmem_wr, text_hit, data_hit, stack_hit;

  sodor_core core (
    .clock                  (clock),
    .reset                  (reset),
    .io_imem_req_bits_addr  (imem_addr),
    .io_imem_resp_bits_data (imem_data),
    .io_dmem_req_bits_addr  (dmem_addr),
    .io_dmem_req_bits_data  (dmem_wdata),
    .io_dmem_req_bits_mask  (dmem_mask),
    .io_dmem_req_wr         (dmem_wr),
    .io_dmem_resp_bits_data (dmem_rdata)
  );

  sodor_text_mem mem_text (
    .clock      (clock),
    .fetch_addr (imem_addr),
    .fetch_data (imem_data),
    .addr       (dmem_addr),
    .we         (dmem_wr),
    .be         (dmem_mask),
    .wdata      (dmem_wdata),
    .hit        (text_hit),
    .rdata      (text_rdata)
  );

  sodor_scratchpad #(.BASE(32'h8000_1000), .WORDS(768)) mem_data (
    .clock (clock),
    .addr  (dmem_addr),
    .we    (dmem_wr),
    .be    (dmem_mask),
    .wdata (dmem_wdata),
    .hit   (data_hit),
    .rdata (data_rdata)
  );

  sodor_scratchpad #(.BASE(32'h8002_0800), .WORDS(512)) mem_stack (
    .clock (clock),
    .addr  (dmem_addr),
    .we    (dmem_wr),
    .be    (dmem_mask),
    .wdata (dmem_wdata),
    .hit   (stack_hit),
    .rdata (stack_rdata)
  );

  // Data overlaps the upper text window, so it must win the load priority
  always_comb begin
    dmem_rdata = '0;
    if (data_hit)       dmem_rdata = data_rdata;
    else if (stack_hit) dmem_rdata = stack_rdata;
    else if (text_hit)  dmem_rdata = text_rdata;
  end
endmodule

// File: tb/tb_sodor_internal_tile.sv
// Directed program-level bench for sodor_internal_tile: preloads text memory and observes
// the PC and rs2 read port ("add x0,x0,xN" exposes xN on rs2_data).

module tb_sodor_internal_tile;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  logic [31:0] prog [$];

  sodor_internal_tile dut (.clock(clock), .reset(reset));

  always #5 clock = ~clock;

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(int imm, int rd, int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(imm, rs1, 0, rd, 'h13);
  endfunction
  function automatic logic [31:0] obs(int r);
    return enc_r(0, r, 0, 0, 0);
  endfunction

  // Holds reset while the program image is written, then releases at a falling edge
  task automatic load_prog(int cycles);
    reset = 1'b1;
    for (int i = 0; i < 1200; i++)
      dut.mem_text.mem[i] <= (i < prog.size()) ? prog[i] : NOP;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    prog = '{obs(2), obs(5)};
    load_prog(5);
    n_total++;
    if (dut.core.io_imem_req_bits_addr !== BASE)
      $display("FAIL reset_pc got %h want %h", dut.core.io_imem_req_bits_addr, BASE);
    else n_pass++;
    n_total++;
    if (dut.core.d.rs2_data !== 32'h8002_1000)
      $display("FAIL reset_sp got %h want %h", dut.core.d.rs2_data, 32'h8002_1000);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (dut.core.d.rs2_data !== 32'h0)
      $display("FAIL reset_x5 got %h want %h", dut.core.d.rs2_data, 32'h0);
    else n_pass++;
    for (int i = 1; i < 4; i++) begin
      n_total++;
      if (dut.core.io_imem_req_bits_addr !== BASE + 32'(4 * i))
        $display("FAIL nop_pc%0d got %h want %h", i, dut.core.io_imem_req_bits_addr, BASE + 32'(4 * i));
      else n_pass++;
      @(negedge clock);
    end
  endtask

  task automatic test_alu();
    logic [31:0] exp_tab [7] = '{32'hFFFF_FFFC, 32'h0000_000F, 32'h1, 32'h0, 32'h0, 32'd14, 32'h0};
    prog = '{addi(5, 0, 7), addi(6, 0, -3), enc_r(0, 6, 5, 0, 7), enc_r('h20, 6, 5, 0, 8),
             obs(7), obs(8), addi(9, 0, -16), enc_i('h402, 9, 5, 10, 'h13),
             enc_i(28, 9, 5, 11, 'h13), enc_r(0, 5, 9, 2, 12), enc_r(0, 5, 9, 3, 13),
             enc_u('h80000, 14, 'h37), enc_r(0, 14, 14, 0, 15), addi(16, 0, 33),
             enc_r(0, 16, 5, 1, 17), addi(0, 0, 5),
             obs(10), obs(11), obs(12), obs(13), obs(15), obs(17), obs(0)};
    load_prog(2);
    repeat (3) @(negedge clock);
    n_total++;
    if (dut.core.d.rs2_data !== 32'hFFFF_FFFD)
      $display("FAIL sub_rs2 got %h want %h", dut.core.d.rs2_data, 32'hFFFF_FFFD);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (dut.core.d.rs2_data !== 32'd4) $display("FAIL add_x7 got %h want %h", dut.core.d.rs2_data, 32'd4);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (dut.core.d.rs2_data !== 32'd10) $display("FAIL sub_x8 got %h want %h", dut.core.d.rs2_data, 32'd10);
    else n_pass++;
    repeat (11) @(negedge clock);
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if (dut.core.d.rs2_data !== exp_tab[i])
        $display("FAIL alu_obs%0d got %h want %h", i, dut.core.d.rs2_data, exp_tab[i]);
      else n_pass++;
      @(negedge clock);
    end
  endtask

  task automatic test_mem();
    logic [31:0] exp_tab [9] = '{32'h55, 32'h55, 32'hFFFF_FF80, 32'h80, 32'hFFFF_FFFF,
                                 32'hFFFF_0055, 32'h80, 32'h0, 32'hFFFF_FFFF};
    prog = '{enc_u('h80001, 1, 'h37), addi(2, 0, 'h55), enc_s(0, 2, 1, 2), enc_i(0, 1, 2, 3, 3),
             enc_s(1, 0, 1, 0), enc_i(0, 1, 5, 4, 3), addi(5, 0, 'h80), enc_s(2, 5, 1, 0),
             enc_i(2, 1, 0, 6, 3), enc_i(2, 1, 4, 7, 3), addi(9, 0, -1), enc_s(2, 9, 1, 1),
             enc_i(2, 1, 1, 10, 3), enc_i(0, 1, 2, 11, 3), enc_u('h80021, 12, 'h37),
             enc_s(-4, 5, 12, 2), enc_i(-4, 12, 2, 13, 3), enc_u('h90000, 14, 'h37),
             enc_s(0, 9, 14, 2), enc_i(0, 14, 2, 15, 3), enc_u('h80000, 17, 'h37),
             enc_s('hA0, 9, 17, 2), enc_i('hA0, 17, 2, 16, 3),
             obs(3), obs(4), obs(6), obs(7), obs(10), obs(11), obs(13), obs(15), obs(16)};
    load_prog(2);
    repeat (23) @(negedge clock);
    for (int i = 0; i < 9; i++) begin
      n_total++;
      if (dut.core.d.rs2_data !== exp_tab[i])
        $display("FAIL mem_obs%0d got %h want %h", i, dut.core.d.rs2_data, exp_tab[i]);
      else n_pass++;
      @(negedge clock);
    end
    n_total++;
    if (dut.mem_text.mem[40] !== 32'hFFFF_FFFF)
      $display("FAIL text_store got %h want %h", dut.mem_text.mem[40], 32'hFFFF_FFFF);
    else n_pass++;
  endtask

  task automatic test_branch();
    int trace [15] = '{0, 2, 5, 6, 3, 4, 7, 8, 9, 10, 12, 13, 15, 17, 19};
    prog = '{enc_b(8, 0, 0, 0), addi(5, 0, 1), enc_j(12, 1), obs(1), enc_j(12, 0),
             addi(6, 0, 2), enc_i(0, 1, 0, 0, 'h67), obs(5), enc_b(8, 0, 0, 1), addi(7, 0, -1),
             enc_b(8, 0, 7, 4), NOP, enc_b(8, 0, 7, 6), enc_b(8, 7, 0, 5), NOP,
             enc_b(8, 0, 7, 7), NOP, enc_i('h41, 1, 0, 0, 'h67), NOP, obs(6)};
    load_prog(2);
    for (int i = 0; i < 15; i++) begin
      n_total++;
      if (dut.core.io_imem_req_bits_addr !== BASE + 32'(4 * trace[i]))
        $display("FAIL br_trace%0d got %h want %h", i, dut.core.io_imem_req_bits_addr, BASE + 32'(4 * trace[i]));
      else n_pass++;
      if (trace[i] == 3) begin
        n_total++;
        if (dut.core.d.rs2_data !== 32'h8000_000C)
          $display("FAIL jal_link got %h want %h", dut.core.d.rs2_data, 32'h8000_000C);
        else n_pass++;
      end
      if (trace[i] == 7) begin
        n_total++;
        if (dut.core.d.rs2_data !== 32'h0)
          $display("FAIL skipped_x5 got %h want %h", dut.core.d.rs2_data, 32'h0);
        else n_pass++;
      end
      if (trace[i] == 19) begin
        n_total++;
        if (dut.core.d.rs2_data !== 32'd2)
          $display("FAIL sub_x6 got %h want %h", dut.core.d.rs2_data, 32'd2);
        else n_pass++;
      end
      @(negedge clock);
    end
  endtask

  // Counts result-store occurrences over a fixed window and checks each value in order
  task automatic run_fib(string tag, int cycles, int want_hits);
    logic [31:0] fib [10] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
    int k = 0;
    for (int c = 0; c < cycles; c++) begin
      if (dut.core.io_imem_req_bits_addr == BASE + 32'h10) begin
        n_total++;
        if (k >= 10 || dut.core.d.rs2_data !== fib[k % 10])
          $display("FAIL %s_val%0d got %h want %h", tag, k, dut.core.d.rs2_data, fib[k % 10]);
        else n_pass++;
        k++;
      end
      @(negedge clock);
    end
    n_total++;
    if (k != want_hits) $display("FAIL %s_count got %0d want %0d", tag, k, want_hits);
    else n_pass++;
  endtask

  task automatic test_fib();
    prog = '{addi(10, 0, 1), addi(11, 0, 1), addi(12, 0, 10), enc_u('h80001, 13, 'h37),
             enc_s('hd0, 10, 13, 2), enc_r(0, 11, 10, 0, 14), addi(10, 11, 0),
             addi(11, 14, 0), addi(12, 12, -1), enc_b(-20, 0, 12, 1), enc_j(0, 0)};
    load_prog(2);
    run_fib("fib", 90, 10);
  endtask

  task automatic test_mid_reset();
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_total++;
    if (dut.core.io_imem_req_bits_addr !== BASE)
      $display("FAIL midrst_pc got %h want %h", dut.core.io_imem_req_bits_addr, BASE);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (dut.core.io_imem_req_bits_addr !== BASE)
      $display("FAIL midrst_hold got %h want %h", dut.core.io_imem_req_bits_addr, BASE);
    else n_pass++;
    reset = 1'b0;
    run_fib("refib", 30, 5);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_fib();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
